// File: rtl/serializador_nrzi.sv
// ---------------------------------------------------------------------------
// serializador_nrzi
//
// Serializes a 32-bit word LSB first onto a single NRZI-encoded line, with
// bit stuffing: after LIMITE_RELLENO consecutive 1 data bits a 0 is inserted
// so that the receiver keeps seeing transitions.
//
// Ports
//   clk          : single clock, everything changes on its rising edge
//   reset        : synchronous active-high reset
//   dato_entrada : 32-bit parallel word to send
//   dato_valido  : dato_entrada holds a word to send
//   listo        : block can accept a word this cycle (idle)
//   dato_sal     : NRZI line level (registered)
//   bit_valido   : dato_sal carries a data or stuff bit this cycle (registered)
//   ocupado      : a word is being serialized
// ---------------------------------------------------------------------------
module serializador_nrzi #(
    parameter int LIMITE_RELLENO = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dato_entrada,
    input  logic        dato_valido,
    output logic        listo,
    output logic        dato_sal,
    output logic        bit_valido,
    output logic        ocupado
);

    localparam int ANCHO_UNOS = $clog2(LIMITE_RELLENO + 1);
    localparam logic [ANCHO_UNOS-1:0] UNOS_MAX = ANCHO_UNOS'(LIMITE_RELLENO);
    localparam logic [ANCHO_UNOS-1:0] UNO      = ANCHO_UNOS'(1);

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        TRANSMITE = 2'd1,
        RELLENO   = 2'd2
    } estado_t;

    // The state describes what is on the line during the current cycle, so
    // the registered outputs are loaded from the values that go with the
    // next state. That is what gives the one-cycle latency from acceptance
    // to the first bit.
    estado_t               estado_q, estado_d;
    logic [31:0]           shift_q, shift_d;
    logic [4:0]            indice_q, indice_d;
    logic [ANCHO_UNOS-1:0] unos_q, unos_d;
    logic                  dato_sal_q, dato_sal_d;
    logic                  bit_valido_q, bit_valido_d;

    // Raw (pre-NRZI) bit going onto the line next cycle; 1 means "hold".
    logic                  bit_d;

    // Values for moving on to the next data bit, shared by TRANSMITE and
    // RELLENO. The shift register holds only the bits not yet sent, so the
    // next one is always in position 0.
    logic [31:0]           sig_shift;
    logic [4:0]            sig_indice;
    logic [ANCHO_UNOS-1:0] sig_unos;
    logic                  sig_bit;

    assign sig_bit    = shift_q[0];
    assign sig_shift  = {1'b0, shift_q[31:1]};
    assign sig_indice = indice_q + 5'd1;
    assign sig_unos   = shift_q[0] ? (unos_q + UNO) : '0;

    // State register plus datapath registers; reset wins over everything,
    // including a word offered at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= REPOSO;
            shift_q      <= '0;
            indice_q     <= '0;
            unos_q       <= '0;
            dato_sal_q   <= 1'b1;
            bit_valido_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            shift_q      <= shift_d;
            indice_q     <= indice_d;
            unos_q       <= unos_d;
            dato_sal_q   <= dato_sal_d;
            bit_valido_q <= bit_valido_d;
        end
    end

    // Next-state and datapath logic. The ones counter already includes the
    // bit currently on the line, so reaching the limit in TRANSMITE means
    // the stuff bit goes out next, before looking at the bit index.
    always_comb begin
        estado_d = estado_q;
        shift_d  = shift_q;
        indice_d = indice_q;
        unos_d   = unos_q;
        bit_d    = 1'b1;

        case (estado_q)
            REPOSO: begin
                if (dato_valido) begin
                    estado_d = TRANSMITE;
                    shift_d  = {1'b0, dato_entrada[31:1]};
                    indice_d = '0;
                    unos_d   = dato_entrada[0] ? UNO : '0;
                    bit_d    = dato_entrada[0];
                end
            end

            TRANSMITE: begin
                if (unos_q == UNOS_MAX) begin
                    estado_d = RELLENO;
                    unos_d   = '0;
                    bit_d    = 1'b0;
                end else if (indice_q == 5'd31) begin
                    estado_d = REPOSO;
                    unos_d   = '0;
                end else begin
                    estado_d = TRANSMITE;
                    shift_d  = sig_shift;
                    indice_d = sig_indice;
                    unos_d   = sig_unos;
                    bit_d    = sig_bit;
                end
            end

            RELLENO: begin
                if (indice_q == 5'd31) begin
                    estado_d = REPOSO;
                end else begin
                    estado_d = TRANSMITE;
                    shift_d  = sig_shift;
                    indice_d = sig_indice;
                    unos_d   = sig_unos;
                    bit_d    = sig_bit;
                end
            end

            default: begin
                estado_d = REPOSO;
                unos_d   = '0;
                indice_d = '0;
            end
        endcase
    end

    // Output logic: NRZI toggles the line on a 0 and holds it on a 1; idle
    // cycles use bit_d = 1 so the line keeps its last level.
    always_comb begin
        dato_sal_d   = bit_d ? dato_sal_q : ~dato_sal_q;
        bit_valido_d = (estado_d != REPOSO);
        listo        = (estado_q == REPOSO);
        ocupado      = (estado_q != REPOSO);
    end

    assign dato_sal   = dato_sal_q;
    assign bit_valido = bit_valido_q;

endmodule

// File: tb/tb_serializador_nrzi.sv
// ---------------------------------------------------------------------------
// tb_serializador_nrzi
//
// Self-checking bench for serializador_nrzi. A reference model turns each
// word into the list of line bits (data plus stuff zeros) and then into
// NRZI levels, and every cycle of the DUT is compared against it.
// ---------------------------------------------------------------------------
module tb_serializador_nrzi;

    localparam int LIMITE = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dato_entrada;
    logic        dato_valido;
    logic        listo;
    logic        dato_sal;
    logic        bit_valido;
    logic        ocupado;

    int testsRun    = 0;
    int testsFailed = 0;

    // Line level the model expects; starts at 1 after reset.
    logic modelLevel;
    // Bits the model expects on the line for the current word.
    bit   expBits[$];

    serializador_nrzi #(
        .LIMITE_RELLENO(LIMITE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dato_entrada(dato_entrada),
        .dato_valido (dato_valido),
        .listo       (listo),
        .dato_sal    (dato_sal),
        .bit_valido  (bit_valido),
        .ocupado     (ocupado)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: list of bits on the line, LSB first, with a 0
    // inserted after every run of LIMITE consecutive data ones.
    task automatic buildExpected(input logic [31:0] w);
        int unos;
        unos = 0;
        expBits.delete();
        for (int i = 0; i < 32; i++) begin
            expBits.push_back(w[i]);
            if (w[i]) unos++;
            else      unos = 0;
            if (unos == LIMITE) begin
                expBits.push_back(1'b0);
                unos = 0;
            end
        end
    endtask

    // Sends one word starting at a falling edge with the DUT idle and checks
    // every bit cycle plus the idle cycle after it. With holdValid the
    // valid line stays high with fresh garbage data during the word, which
    // must be ignored; the caller then offers the next word on that idle
    // cycle.
    task automatic applyStimulus(input logic [31:0] w, input bit holdValid, input string name);
        buildExpected(w);
        checkOutput({name, ".listo_antes"}, listo, 1);
        dato_entrada = w;
        dato_valido  = 1'b1;
        for (int k = 0; k < expBits.size(); k++) begin
            @(negedge clk);
            modelLevel = expBits[k] ? modelLevel : ~modelLevel;
            checkOutput($sformatf("%s.bit_valido[%0d]", name, k + 1), bit_valido, 1);
            checkOutput($sformatf("%s.dato_sal[%0d]", name, k + 1), dato_sal, modelLevel);
            checkOutput($sformatf("%s.ocupado[%0d]", name, k + 1), ocupado, 1);
            checkOutput($sformatf("%s.listo[%0d]", name, k + 1), listo, 0);
            if (holdValid) dato_entrada = $urandom;
            else           dato_valido  = 1'b0;
        end
        @(negedge clk);
        checkOutput({name, ".bit_valido_fin"}, bit_valido, 0);
        checkOutput({name, ".ocupado_fin"}, ocupado, 0);
        checkOutput({name, ".listo_fin"}, listo, 1);
        checkOutput({name, ".dato_sal_fin"}, dato_sal, modelLevel);
    endtask

    initial begin
        logic [31:0] w;
        bit          hold;

        reset        = 1'b1;
        dato_valido  = 1'b0;
        dato_entrada = '0;
        modelLevel   = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.dato_sal", dato_sal, 1);
        checkOutput("reset.bit_valido", bit_valido, 0);
        checkOutput("reset.ocupado", ocupado, 0);
        checkOutput("reset.listo", listo, 1);
        reset = 1'b0;
        @(negedge clk);

        // Directed words: all zeros, all ones, a single stuff, and a stuff
        // caused by bit 31 itself.
        applyStimulus(32'h0000_0000, 1'b0, "ceros");
        applyStimulus(32'hFFFF_FFFF, 1'b0, "unos");
        applyStimulus(32'h0000_003F, 1'b0, "seis_unos");
        applyStimulus(32'hFC00_0000, 1'b0, "relleno_final");

        // Valid held high with changing data while busy; second word only
        // goes in once the first has finished.
        applyStimulus(32'hA5A5_00FF, 1'b1, "sostenido");
        applyStimulus(32'h0F0F_1234, 1'b0, "segunda");

        // Random words, half of them biased towards long runs of ones.
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            if (i % 2 == 1) w = w | $urandom | $urandom;
            hold = 1'($urandom_range(0, 1));
            applyStimulus(w, hold, $sformatf("aleatorio%0d", i));
        end
        dato_valido = 1'b0;
        @(negedge clk);

        // Reset in the middle of a word: after 10 bit cycles.
        w = $urandom;
        buildExpected(w);
        dato_entrada = w;
        dato_valido  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            modelLevel = expBits[k] ? modelLevel : ~modelLevel;
            checkOutput($sformatf("abortado.dato_sal[%0d]", k + 1), dato_sal, modelLevel);
            checkOutput($sformatf("abortado.bit_valido[%0d]", k + 1), bit_valido, 1);
            dato_valido = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        modelLevel = 1'b1;
        checkOutput("abortado.dato_sal_reset", dato_sal, 1);
        checkOutput("abortado.bit_valido_reset", bit_valido, 0);
        checkOutput("abortado.ocupado_reset", ocupado, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checkOutput($sformatf("abortado.residuo[%0d]", k), bit_valido, 0);
            checkOutput($sformatf("abortado.linea[%0d]", k), dato_sal, 1);
        end

        // Word offered on the same edge as reset must be dropped.
        reset        = 1'b1;
        dato_valido  = 1'b1;
        dato_entrada = 32'h8000_0000;
        @(negedge clk);
        reset       = 1'b0;
        dato_valido = 1'b0;
        checkOutput("simultaneo.listo", listo, 1);
        checkOutput("simultaneo.bit_valido", bit_valido, 0);
        checkOutput("simultaneo.ocupado", ocupado, 0);
        checkOutput("simultaneo.dato_sal", dato_sal, 1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checkOutput($sformatf("simultaneo.residuo[%0d]", k), bit_valido, 0);
        end

        // Normal operation after the reset cases.
        applyStimulus(32'h8000_0000, 1'b0, "tras_reset");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
